// File: rtl/seq_bin_to_bcd_seg.sv
// -----------------------------------------------------------------------------
// seq_bin_to_bcd_seg
//
// Sequential binary-to-decimal display driver. An accepted start captures an
// IN_W-bit unsigned value and converts it to DIGITS BCD digits with the
// shift-add-3 (double dabble) algorithm, one input bit per clock. When the last
// bit has been shifted in, the digits, the overflow flag and one active-low
// 7-segment pattern per digit are registered together and done pulses for one
// cycle. Results hold until the next conversion completes.
//
// Parameters
//   IN_W           width of the binary input (>= 1)
//   DIGITS         number of BCD digits / displays (>= 1)
//   BLANK_LEADING  1: blank zero digits above the most significant non-zero
//                  digit (ones digit always shown); 0: show every digit
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   conversion request, only sampled while busy = 0
//   bin       in   [IN_W-1:0]      value captured on the accepted start edge
//   busy      out  conversion in progress
//   done      out  one-cycle pulse, bcd/seg/overflow have just been updated
//   overflow  out  last value did not fit in DIGITS decimal digits
//   bcd       out  [4*DIGITS-1:0]  result digits, [3:0] = ones, [7:4] = tens ...
//   seg       out  [7*DIGITS-1:0]  patterns, [6:0] = ones, bit order {g,f,e,d,c,b,a},
//                                  0 = segment lit
// -----------------------------------------------------------------------------
module seq_bin_to_bcd_seg #(
    parameter int IN_W          = 8,
    parameter int DIGITS        = 3,
    parameter int BLANK_LEADING = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg
);

    // Counter must hold the value IN_W itself.
    localparam int CNT_W = $clog2(IN_W + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [0:0]          state;
    logic [IN_W-1:0]     shreg;   // binary bits still to be shifted in
    logic [4*DIGITS-1:0] dig;     // scratch BCD digits
    logic [CNT_W-1:0]    cnt;     // shifts remaining in this conversion
    logic                ovf;     // sticky: a 1 left the top digit

    // -------------------------------------------------------------------------
    // One shift-add-3 step, computed from the current scratch state
    // -------------------------------------------------------------------------
    logic [4*DIGITS-1:0] adj;
    logic [4*DIGITS-1:0] dig_nx;
    logic [IN_W-1:0]     sh_nx;
    logic                ovf_nx;

    // NOTE: every variable assigned in an always_comb gets a default at the top
    // of the block, so no path can leave it unassigned and infer a latch.
    always_comb begin
        adj = dig;
        for (int k = 0; k < DIGITS; k++) begin
            // Each digit is corrected on its own; a digit >= 5 becomes >= 8 so
            // the following shift carries it into the next digit as a decimal
            // carry. No carry ripples between digits here.
            if (dig[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = dig[4*k +: 4] + 4'd3;
            end
        end
        dig_nx = {adj[4*DIGITS-2:0], shreg[IN_W-1]};
        sh_nx  = shreg << 1;
        // The bit leaving the top digit is a carry into a digit we do not
        // have; once set, the result no longer fits.
        ovf_nx = ovf | adj[4*DIGITS-1];
    end

    // -------------------------------------------------------------------------
    // 7-segment decode of the post-shift digits (used on the final shift only)
    // -------------------------------------------------------------------------
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = SEG_BLANK;  // 10..15 cannot come out of the converter
        endcase
        return p;
    endfunction

    logic [7*DIGITS-1:0] seg_nx;
    logic                upper_zero;

    always_comb begin
        seg_nx     = '1;
        upper_zero = 1'b1;
        // Walk from the most significant digit down; upper_zero stays set while
        // this digit and every digit above it are zero.
        for (int k = DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero & (dig_nx[4*k +: 4] == 4'd0);
            if (ovf_nx) begin
                seg_nx[7*k +: 7] = SEG_DASH;
            end else if ((BLANK_LEADING != 0) && (k > 0) && upper_zero) begin
                seg_nx[7*k +: 7] = SEG_BLANK;
            end else begin
                seg_nx[7*k +: 7] = decode(dig_nx[4*k +: 4]);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM and registered outputs
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            dig      <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            bcd      <= '0;
            seg      <= '1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // busy is low in IDLE, including the done cycle, so a
                    // start there chains straight into the next conversion.
                    if (start) begin
                        shreg <= bin;
                        dig   <= '0;
                        ovf   <= 1'b0;
                        cnt   <= CNT_W'(IN_W);
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg <= sh_nx;
                    dig   <= dig_nx;
                    ovf   <= ovf_nx;
                    cnt   <= cnt - CNT_W'(1);
                    // Final shift: publish the post-shift value in this edge
                    // rather than spending an extra cycle.
                    if (cnt == CNT_W'(1)) begin
                        bcd      <= dig_nx;
                        overflow <= ovf_nx;
                        seg      <= seg_nx;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
